reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: SP_INIT, 32'h0000_3FFC, value loaded into register 29 ($sp) on reset.
REQ-002 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high; sampled on rising edge of clock.
REQ-004 Port: RegWrite  input  1  write enable for the write port.
REQ-005 Port: read_r1  input  5  register index, read port 1 (rs).
REQ-006 Port: read_r2  input  5  register index, read port 2 (rt).
REQ-007 Port: write_r  input  5  register index, write port (rd/rt from writeback).
REQ-008 Port: write_d  input  32  write data from writeback stage.
REQ-009 Port: read_d1  output  32  data for read_r1 (feeds ALU operand 1).
REQ-010 Port: read_d2  output  32  data for read_r2 (feeds ALU operand-2 source mux and store data).

Function
REQ-011 Storage SHALL be 32 registers x 32 bits, indices 0..31.
REQ-012 Register 0 SHALL read as 32'h0 on both ports at all times; writes to index 0 SHALL be discarded with no state change.
REQ-013 Write: on rising edge with reset=0, RegWrite=1, write_r!=0 -> reg[write_r] <= write_d; all other registers hold.
REQ-014 RegWrite=0 SHALL leave every register unchanged regardless of write_r/write_d.
REQ-015 Reads SHALL be combinational (zero-cycle latency): read_dN follows read_rN and register contents within the same cycle.
REQ-016 Write-first bypass: when reset=0, RegWrite=1, write_r!=0 and write_r==read_rN, read_dN SHALL equal write_d in that same cycle (before the edge commits it).
REQ-017 Bypass SHALL apply independently to each port; both ports SHALL bypass when read_r1==read_r2==write_r.
REQ-018 Bypass SHALL NOT apply for write_r==0 or while reset=1; read_dN then reflects stored contents (or 0 for index 0).
REQ-019 After the edge, read_dN for the written index SHALL return the committed value with no further delay (bypass and stored value equal, no glitch in value across the edge).
REQ-020 Same-index writes on consecutive cycles: last write wins; each intermediate value visible via bypass in its own cycle.
REQ-021 No read side effects; read_r1/read_r2 may take any value every cycle, including equal indices.
REQ-022 All outputs SHALL be full 32-bit; no sign or width conversion inside the block.

Reset
REQ-023 On rising edge with reset=1: all registers <= 32'h0 except reg[29] <= SP_INIT.
REQ-024 A write presented in the reset cycle SHALL be discarded (reset has priority over RegWrite).
REQ-025 Reset asserted mid-operation SHALL take effect on the next rising edge only; before that edge contents are unchanged.
REQ-026 After reset deassertion the first edge SHALL accept writes normally.
REQ-027 Output values after reset (no write pending): read_dN = 0 for all indices except 29 -> SP_INIT.

Verification
REQ-028 Reset then read all 32 indices on both ports -> 0 everywhere, index 29 -> 32'h0000_3FFC.
REQ-029 Write reg 8 <= 32'hDEAD_BEEF, next cycle read_r1=8, read_r2=8 -> both 32'hDEAD_BEEF; reg 9 still 0.
REQ-030 Same cycle RegWrite=1, write_r=5, write_d=32'h1234_5678, read_r2=5 -> read_d2=32'h1234_5678 before the edge; read_r1=6 unaffected.
REQ-031 RegWrite=1, write_r=0, write_d=32'hFFFF_FFFF, read_r1=0 -> read_d1=0 in that cycle and after.
REQ-032 RegWrite=1, write_r=3, write_d=32'hA5A5_A5A5 with reset=1 -> after edge reg 3 = 0, read_d1(3) = 0; bypass not shown during the cycle.
REQ-033 RegWrite=0, write_r=7, write_d=32'h1, read_r1=7 -> read_d1 stays prior value (0) before and after edge.

Source files
------------

// File: rtl/reg_file_if.sv
// Register-file access bus: two combinational read ports and one write port.
interface reg_file_if;
   logic        RegWrite;
   logic [4:0]  read_r1;
   logic [4:0]  read_r2;
   logic [4:0]  write_r;
   logic [31:0] write_d;
   logic [31:0] read_d1;
   logic [31:0] read_d2;

   modport master (
      output RegWrite,
      output read_r1,
      output read_r2,
      output write_r,
      output write_d,
      input  read_d1,
      input  read_d2
   );

   modport slave (
      input  RegWrite,
      input  read_r1,
      input  read_r2,
      input  write_r,
      input  write_d,
      output read_d1,
      output read_d2
   );
endinterface

// File: rtl/reg_file.sv
// 32 x 32 register file, two read ports and one write port.
// Register 0 is hardwired to zero. Reads are combinational, with a
// write-first bypass so a value being written is visible in the same cycle.
// Reset loads register 29 (stack pointer) with SP_INIT and clears the rest.
module reg_file #(
   parameter logic [31:0] SP_INIT = 32'h0000_3FFC
) (
   input  logic       clock,
   input  logic       reset,
   reg_file_if.slave  rf
);

   logic [31:0] regs [32];
   logic        wr_en;

   // A write only takes effect outside reset and never to register 0.
   assign wr_en = rf.RegWrite && !reset && (rf.write_r != 5'd0);

   // Register storage: synchronous reset has priority over the write port.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (i == 29) ? SP_INIT : 32'h0;
         end
      end else if (wr_en) begin
         regs[rf.write_r] <= rf.write_d;
      end
   end

   // Read port 1: zero for index 0, bypass on a matching write, else storage.
   always_comb begin
      rf.read_d1 = 32'h0;
      if (rf.read_r1 == 5'd0) begin
         rf.read_d1 = 32'h0;
      end else if (wr_en && (rf.write_r == rf.read_r1)) begin
         rf.read_d1 = rf.write_d;
      end else begin
         rf.read_d1 = regs[rf.read_r1];
      end
   end

   // Read port 2: same selection as port 1, evaluated independently.
   always_comb begin
      rf.read_d2 = 32'h0;
      if (rf.read_r2 == 5'd0) begin
         rf.read_d2 = 32'h0;
      end else if (wr_en && (rf.write_r == rf.read_r2)) begin
         rf.read_d2 = rf.write_d;
      end else begin
         rf.read_d2 = regs[rf.read_r2];
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset contents, writes, bypass, r0 and reset priority.
module tb_reg_file;

   localparam logic [31:0] SP_INIT = 32'h0000_3FFC;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fails;

   reg_file_if rf_bus ();

   reg_file #(.SP_INIT(SP_INIT)) dut (
      .clock (clock),
      .reset (reset),
      .rf    (rf_bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
      rf_bus.RegWrite = we;
      rf_bus.write_r  = wr;
      rf_bus.write_d  = wd;
      rf_bus.read_r1  = r1;
      rf_bus.read_r2  = r2;
   endtask

   // Advance through one rising edge and settle just after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Move to the low phase so inputs change away from the active edge.
   task automatic to_low();
      @(negedge clock);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset    = 1'b1;
      set_in(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      step();
      step();
      to_low();
      reset = 1'b0;

      // Reset contents on both ports
      for (int i = 0; i < 32; i++) begin
         set_in(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         #1;
         check_eq($sformatf("rst_d1[%0d]", i), rf_bus.read_d1, (i == 29) ? SP_INIT : 32'h0);
         check_eq($sformatf("rst_d2[%0d]", 31 - i), rf_bus.read_d2, ((31 - i) == 29) ? SP_INIT : 32'h0);
      end

      // Write reg 8, read it back on both ports, reg 9 untouched
      to_low();
      set_in(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
      step();
      to_low();
      set_in(1'b0, 5'd8, 32'h0, 5'd8, 5'd8);
      #1;
      check_eq("wr8_d1", rf_bus.read_d1, 32'hDEAD_BEEF);
      check_eq("wr8_d2", rf_bus.read_d2, 32'hDEAD_BEEF);
      rf_bus.read_r1 = 5'd9;
      #1;
      check_eq("reg9_zero", rf_bus.read_d1, 32'h0);

      // Same-cycle bypass on port 2 only, then committed value after the edge
      to_low();
      set_in(1'b1, 5'd5, 32'h1234_5678, 5'd6, 5'd5);
      #1;
      check_eq("byp5_d2", rf_bus.read_d2, 32'h1234_5678);
      check_eq("byp5_d1_r6", rf_bus.read_d1, 32'h0);
      step();
      check_eq("post5_edge_d2", rf_bus.read_d2, 32'h1234_5678);
      to_low();
      rf_bus.RegWrite = 1'b0;
      #1;
      check_eq("post5_stored_d2", rf_bus.read_d2, 32'h1234_5678);

      // Writes to r0 are discarded and never bypassed
      to_low();
      set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
      #1;
      check_eq("r0_byp_d1", rf_bus.read_d1, 32'h0);
      check_eq("r0_byp_d2", rf_bus.read_d2, 32'h0);
      step();
      to_low();
      rf_bus.RegWrite = 1'b0;
      #1;
      check_eq("r0_after_d1", rf_bus.read_d1, 32'h0);

      // RegWrite=0 leaves reg 7 unchanged
      to_low();
      set_in(1'b0, 5'd7, 32'h0000_0001, 5'd7, 5'd8);
      #1;
      check_eq("nowe7_before", rf_bus.read_d1, 32'h0);
      step();
      check_eq("nowe7_after", rf_bus.read_d1, 32'h0);
      check_eq("nowe_r8_hold", rf_bus.read_d2, 32'hDEAD_BEEF);

      // Both ports bypass the same index
      to_low();
      set_in(1'b1, 5'd10, 32'hCAFE_F00D, 5'd10, 5'd10);
      #1;
      check_eq("byp10_d1", rf_bus.read_d1, 32'hCAFE_F00D);
      check_eq("byp10_d2", rf_bus.read_d2, 32'hCAFE_F00D);
      step();
      to_low();
      rf_bus.RegWrite = 1'b0;
      #1;
      check_eq("st10_d1", rf_bus.read_d1, 32'hCAFE_F00D);

      // Consecutive writes to reg 11: each visible by bypass, last one wins
      to_low();
      set_in(1'b1, 5'd11, 32'h0000_0111, 5'd11, 5'd10);
      #1;
      check_eq("seq11_a", rf_bus.read_d1, 32'h0000_0111);
      step();
      to_low();
      rf_bus.write_d = 32'h0000_0222;
      #1;
      check_eq("seq11_b", rf_bus.read_d1, 32'h0000_0222);
      step();
      to_low();
      rf_bus.write_d = 32'h0000_0333;
      #1;
      check_eq("seq11_c", rf_bus.read_d1, 32'h0000_0333);
      step();
      to_low();
      rf_bus.RegWrite = 1'b0;
      #1;
      check_eq("seq11_final", rf_bus.read_d1, 32'h0000_0333);
      check_eq("seq11_r10_hold", rf_bus.read_d2, 32'hCAFE_F00D);

      // Write during reset: no bypass, contents unchanged until the edge, then cleared
      to_low();
      reset = 1'b1;
      set_in(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd8);
      #1;
      check_eq("rstwr_nobyp_d1", rf_bus.read_d1, 32'h0);
      check_eq("rst_pre_edge_r8", rf_bus.read_d2, 32'hDEAD_BEEF);
      step();
      check_eq("rstwr_r3_zero", rf_bus.read_d1, 32'h0);
      check_eq("rst_r8_cleared", rf_bus.read_d2, 32'h0);
      to_low();
      reset = 1'b0;
      set_in(1'b0, 5'd0, 32'h0, 5'd29, 5'd11);
      #1;
      check_eq("rst_sp_init", rf_bus.read_d1, SP_INIT);
      check_eq("rst_r11_cleared", rf_bus.read_d2, 32'h0);

      // First edge after reset accepts a write, including to $sp
      to_low();
      set_in(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd29);
      step();
      to_low();
      set_in(1'b1, 5'd29, 32'h0000_1000, 5'd3, 5'd29);
      #1;
      check_eq("post_rst_wr3", rf_bus.read_d1, 32'hA5A5_A5A5);
      check_eq("sp_bypass", rf_bus.read_d2, 32'h0000_1000);
      step();
      to_low();
      rf_bus.RegWrite = 1'b0;
      #1;
      check_eq("sp_stored", rf_bus.read_d2, 32'h0000_1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
